// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LU   = 2'd1,
        ST_SW   = 2'd2,
        ST_MW   = 2'd3
    } hz_state_e;

    localparam logic [1:0] MASK_B = 2'd0;
    localparam logic [1:0] MASK_H = 2'd1;
    localparam logic [1:0] MASK_W = 2'd2;

    // Byte and half stores need a read-modify-write of the memory word.
    function automatic logic is_subword(input logic [1:0] mask);
        return (mask == MASK_B) || (mask == MASK_H);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, never wrapping past all-ones.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, sub-word RMW freezes,
// taken-branch redirects and data-memory wait stalls, plus perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W           = 5,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int SUBWORD_CYCLES  = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_memRead,
    input  logic             id_ex_memWrite,
    input  logic [1:0]       id_ex_jump,
    input  logic             id_ex_branch,
    input  logic             alu_result_0,
    input  logic             id_ex_imm_31,
    input  logic             ex_mem_memRead,
    input  logic             ex_mem_memWrite,
    input  logic [1:0]       ex_mem_maskMode,
    input  logic             dmem_ready,
    output logic             pcFromTaken,
    output logic             pcStall,
    output logic             IF_ID_stall,
    output logic             ID_EX_stall,
    output logic             EX_MEM_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] LU_REM = 2'(LOAD_USE_CYCLES - 1);
    localparam logic [1:0] SW_REM = 2'(SUBWORD_CYCLES - 1);

    // Control vector bit order matches the output port list.
    localparam logic [7:0] CTRL_NONE = 8'b0000_0000;
    localparam logic [7:0] CTRL_LU   = 8'b0110_0010;
    localparam logic [7:0] CTRL_SW   = 8'b0111_0001;
    localparam logic [7:0] CTRL_TK   = 8'b1000_0110;
    localparam logic [7:0] CTRL_MW   = 8'b0111_1000;

    hz_state_e  state_r, state_nx, saved_r, saved_nx, eff_s;
    logic [1:0] rem_r, rem_nx;
    logic [7:0] ctrl_s;
    logic       taken_s, lu_hz_s, sw_hz_s, mw_s;
    logic       jump_hi_unused;

    assign jump_hi_unused = id_ex_jump[1];

    assign taken_s = id_ex_jump[0] | (id_ex_branch & (alu_result_0 ^ id_ex_imm_31));
    assign lu_hz_s = id_ex_memRead && (id_ex_rd != {REG_W{1'b0}}) &&
                     ((id_uses_rs1 && (rs1 == id_ex_rd)) ||
                      (id_uses_rs2 && (rs2 == id_ex_rd)));
    assign sw_hz_s = ex_mem_memWrite && is_subword(ex_mem_maskMode) &&
                     (id_ex_memRead || id_ex_memWrite);
    assign mw_s    = (ex_mem_memRead || ex_mem_memWrite) && !dmem_ready;

    // Next-state and control decode; a finished memory wait behaves as the saved state.
    always_comb begin
        ctrl_s   = CTRL_NONE;
        state_nx = state_r;
        saved_nx = saved_r;
        rem_nx   = rem_r;
        eff_s    = (state_r == ST_MW) ? saved_r : state_r;
        if (reset) begin
            ctrl_s = CTRL_NONE;
        end else if (mw_s) begin
            ctrl_s   = CTRL_MW;
            state_nx = ST_MW;
            saved_nx = (state_r == ST_MW) ? saved_r : state_r;
        end else begin
            saved_nx = ST_IDLE;
            case (eff_s)
                ST_LU, ST_SW: begin
                    ctrl_s   = (eff_s == ST_LU) ? CTRL_LU : CTRL_SW;
                    rem_nx   = rem_r - 2'd1;
                    state_nx = (rem_r <= 2'd1) ? ST_IDLE : eff_s;
                end
                ST_IDLE: begin
                    state_nx = ST_IDLE;
                    if (sw_hz_s) begin
                        ctrl_s = CTRL_SW;
                        if (SUBWORD_CYCLES > 1) begin
                            state_nx = ST_SW;
                            rem_nx   = SW_REM;
                        end else begin
                            rem_nx = rem_r;
                        end
                    end else if (taken_s) begin
                        ctrl_s = CTRL_TK;
                    end else if (lu_hz_s) begin
                        ctrl_s = CTRL_LU;
                        if (LOAD_USE_CYCLES > 1) begin
                            state_nx = ST_LU;
                            rem_nx   = LU_REM;
                        end else begin
                            rem_nx = rem_r;
                        end
                    end else begin
                        ctrl_s = CTRL_NONE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State, remaining-cycle and return-state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            rem_r   <= 2'd0;
            saved_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
            rem_r   <= rem_nx;
            saved_r <= saved_nx;
        end
    end

    assign {pcFromTaken, pcStall, IF_ID_stall, ID_EX_stall,
            EX_MEM_stall, IF_ID_flush, ID_EX_flush, EX_MEM_flush} = ctrl_s;
    assign state = state_r;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (pcStall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (pcFromTaken),
        .count (flush_cnt)
    );

endmodule
